// File: rtl/usr_serial_tx.sv
// usr_serial_tx: framed serial transmitter for a WIDTH-bit parallel word.
// A word is taken over a valid/ready handshake. It is sent as one start bit (0),
// then WIDTH data bits (MSB- or LSB-first, chosen per word), then one stop bit (1).
// Each bit lasts CLKS_PER_BIT clock cycles. The line idles high.
module usr_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  // Counter widths never drop below one bit, so C=1 and WIDTH=1 still elaborate.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             msb_q, msb_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             period_end;
  logic [BIT_W-1:0] sel_idx;

  // A bit period ends in the cycle where the clock counter holds its last value.
  assign period_end = (clk_cnt_q == CNT_LAST);

  // Ready is decoded from the registered state, so it has no path from the inputs.
  assign in_ready = (state_q == IDLE);
  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // State register: holds the FSM state, counters, captured word and registered outputs.
  // Reset aborts any frame at once and puts the line back to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      buf_q     <= '0;
      msb_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      buf_q     <= buf_d;
      msb_q     <= msb_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: step through the bit periods and capture the word at the handshake.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    buf_d     = buf_q;
    msb_d     = msb_q;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (in_valid && in_ready) begin
          state_d = START;
          buf_d   = in_data;
          msb_d   = msb_first;
        end
      end

      START: begin
        if (period_end) begin
          state_d   = DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (period_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (period_end) begin
          state_d   = IDLE;
          clk_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output logic: outputs are computed from the next state, so the registered
  // line changes on the same edge as the state, which is always a bit-period boundary.
  always_comb begin
    sel_idx = msb_d ? (BIT_LAST - bit_cnt_d) : bit_cnt_d;
    tx_d    = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = buf_d[sel_idx];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

endmodule

// File: doc/usr_serial_tx.md
Name: usr_serial_tx

Overview:
- Downstream consumer of the 4-bit universal shift register word.
- Accepts a parallel word over a valid/ready handshake and serialises it onto a single line as a framed bit stream: start bit, data bits, stop bit.
- Bit order (MSB- or LSB-first) is selectable per word.
- Bit period is set by a clock-count parameter, so the block also acts as the register's line driver at a slower bit rate.

Parameters:
- WIDTH, 4, data word width in bits; must be >= 1.
- CLKS_PER_BIT, 4, clk cycles per serial bit period; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a word on in_data.
- in_data  input  WIDTH  parallel word, typically the shift register's y_out.
- msb_first  input  1  1 = send in_data[WIDTH-1] first; 0 = send in_data[0] first. Sampled at handshake.
- in_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, tx_out=1, busy=0, done=0, in_ready=1, bit and clock counters cleared, shift buffer cleared. Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- States: IDLE, START, DATA, STOP.
- in_ready = (state == IDLE), decoded from registered state.
- Handshake: a word is accepted on a rising edge where in_valid && in_ready. in_data and msb_first are ignored at all other times.
- Let T be the handshake edge and C = CLKS_PER_BIT.
- At edge T:
  - Capture in_data into the internal buffer and latch msb_first.
  - Move to START, drive tx_out=0, set busy=1, clear the clock counter.
- START: tx_out=0 from edge T to edge T+C, then enter DATA with bit index 0.
- DATA:
  - Bit i (0..WIDTH-1) drives tx_out from edge T+C*(1+i) to edge T+C*(2+i).
  - Bit i is buffer[i] when msb_first=0, and buffer[WIDTH-1-i] when msb_first=1. Shift-buffer or index-mux implementation is free, provided this order holds.
  - After bit WIDTH-1, enter STOP.
- STOP: tx_out=1 from edge T+C*(WIDTH+1) to edge T+C*(WIDTH+2).
- At edge T+C*(WIDTH+2):
  - Return to IDLE with busy=0 and done=1 for exactly one cycle.
  - in_ready=1 from that edge, so the earliest next handshake is edge T+C*(WIDTH+2)+1.
  - Minimum frame-to-frame spacing is C*(WIDTH+2)+1 cycles.
- Counters:
  - Clock counter width is clog2(C) (min 1) and counts 0..C-1. A bit period ends on the cycle where the counter reaches C-1.
  - Bit counter width is clog2(WIDTH) (min 1).
  - No wrap beyond these ranges.
- C=1: each bit lasts exactly one cycle. No extra idle cycles inside the frame.
- Glitch freedom: tx_out, busy and done are registered outputs.
- tx_out changes only on bit-period boundaries.
- in_valid held high continuously: words are accepted back to back, each one cycle after the previous done.

Test Plan:
- Reset value check: assert rst low mid-DATA of an in-flight frame -> next sample shows tx_out=1, busy=0, done=0, in_ready=1. After rst high, no further transitions until a new handshake.
- WIDTH=4, C=2, in_data=4'hA, msb_first=0 -> tx_out per 2-cycle period = 0 (start), 0, 1, 0, 1, 1 (stop). done pulses once, 12 cycles after the handshake edge.
- Same word 4'hA, msb_first=1 -> data periods 1, 0, 1, 0. Frame length unchanged at 12 cycles.
- Back-to-back: in_valid held high with 4'h3 then 4'hC, C=1, msb_first=0 -> frames 0,1,1,0,0,1 and 0,0,0,1,1,1. Second handshake occurs exactly 1 cycle after the first done. in_ready=0 throughout each frame.
- in_data changed mid-frame (4'hF to 4'h0 during DATA) -> serial bits still reflect the captured 4'hF. The new value is not accepted until in_ready=1.
- C=1, WIDTH=4: done asserted exactly 6 cycles after the handshake edge. busy high for exactly 6 cycles.
